// File: rtl/regfile_sb_pkg.sv
// Shared defaults for the scoreboarded register file.
package regfile_sb_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned REG_ZERO   = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set by an issuing producer, cleared by its writeback.
module rf_scoreboard
   import regfile_sb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              set_busy,
   input  logic [ADDR_W-1:0] sb_addr,
   input  logic              commit_a,
   input  logic [ADDR_W-1:0] wa_a,
   input  logic              commit_b,
   input  logic [ADDR_W-1:0] wa_b,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic [ADDR_W-1:0] ra3,
   output logic              busy1,
   output logic              busy2,
   output logic              busy3
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [ADDR_W-1:0] ra [3];
   logic              busy [3];

   assign ra[0] = ra1;
   assign ra[1] = ra2;
   assign ra[2] = ra3;

   // Set is applied after the clears so a new producer wins over a retiring one.
   always_comb begin
      busy_d = busy_q;
      if (commit_a) busy_d[wa_a] = 1'b0;
      if (commit_b) busy_d[wa_b] = 1'b0;
      if (set_busy && (sb_addr != ZERO_ADDR)) busy_d[sb_addr] = 1'b1;
      busy_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // A same-cycle writeback hides the busy bit, unless a new producer claims the register.
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         busy[p] = rst_n && busy_q[ra[p]]
                   && !((BYPASS != 0)
                        && ((commit_a && (wa_a == ra[p])) || (commit_b && (wa_b == ra[p])))
                        && !(set_busy && (sb_addr == ra[p])));
      end
   end

   assign busy1 = busy[0];
   assign busy2 = busy[1];
   assign busy3 = busy[2];

endmodule

// File: rtl/regfile_sb.sv
// Three-read, two-write register file with optional write forwarding and busy scoreboard.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   input  logic [ADDR_W-1:0] ra3,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   output logic [DATA_W-1:0] rd3,
   output logic              busy1,
   output logic              busy2,
   output logic              busy3,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] wa_a,
   input  logic [DATA_W-1:0] wd_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] wa_b,
   input  logic [DATA_W-1:0] wd_b,
   input  logic              set_busy,
   input  logic [ADDR_W-1:0] sb_addr
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic              commit_a, commit_b;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [ADDR_W-1:0] ra [3];
   logic [DATA_W-1:0] rd [3];

   assign commit_a = we_a && (wa_a != ZERO_ADDR);
   assign commit_b = we_b && (wa_b != ZERO_ADDR);

   // Port B is written last, so it wins an address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         if (commit_a) regs_q[wa_a] <= wd_a;
         if (commit_b) regs_q[wa_b] <= wd_b;
      end
   end

   assign ra[0] = ra1;
   assign ra[1] = ra2;
   assign ra[2] = ra3;

   always_comb begin
      for (int p = 0; p < 3; p++) begin
         rd[p] = '0;
         if (rst_n && (ra[p] != ZERO_ADDR)) begin
            rd[p] = regs_q[ra[p]];
            if (BYPASS != 0) begin
               if (commit_b && (wa_b == ra[p])) rd[p] = wd_b;
               else if (commit_a && (wa_a == ra[p])) rd[p] = wd_a;
            end
         end
      end
   end

   assign rd1 = rd[0];
   assign rd2 = rd[1];
   assign rd3 = rd[2];

   rf_scoreboard #(
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_busy (set_busy),
      .sb_addr  (sb_addr),
      .commit_a (commit_a),
      .wa_a     (wa_a),
      .commit_b (commit_b),
      .wa_b     (wa_b),
      .ra1      (ra1),
      .ra2      (ra2),
      .ra3      (ra3),
      .busy1    (busy1),
      .busy2    (busy2),
      .busy3    (busy3)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one forwarding and one non-forwarding instance on shared stimulus.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  ra [3];
   logic        we_a, we_b, set_busy;
   logic [4:0]  wa_a, wa_b, sb_addr;
   logic [31:0] wd_a, wd_b;
   logic [31:0] rdv [2][3];   // [0] = no forwarding, [1] = forwarding
   logic        bsv [2][3];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state
   logic [31:0] mem [32];
   logic        pend [32];

   always #5 clk = ~clk;

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nobyp (
      .clk(clk), .rst_n(rst_n),
      .ra1(ra[0]), .ra2(ra[1]), .ra3(ra[2]),
      .rd1(rdv[0][0]), .rd2(rdv[0][1]), .rd3(rdv[0][2]),
      .busy1(bsv[0][0]), .busy2(bsv[0][1]), .busy3(bsv[0][2]),
      .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
      .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
      .set_busy(set_busy), .sb_addr(sb_addr)
   );

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
      .clk(clk), .rst_n(rst_n),
      .ra1(ra[0]), .ra2(ra[1]), .ra3(ra[2]),
      .rd1(rdv[1][0]), .rd2(rdv[1][1]), .rd3(rdv[1][2]),
      .busy1(bsv[1][0]), .busy2(bsv[1][1]), .busy3(bsv[1][2]),
      .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
      .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
      .set_busy(set_busy), .sb_addr(sb_addr)
   );

   function automatic logic [31:0] m_rd(input logic [4:0] a, input int byp);
      if (!rst_n || a == 0) return 32'h0;
      if (byp != 0 && we_b && wa_b == a) return wd_b;
      if (byp != 0 && we_a && wa_a == a) return wd_a;
      return mem[a];
   endfunction

   function automatic logic m_busy(input logic [4:0] a, input int byp);
      logic written;
      if (!rst_n || a == 0) return 1'b0;
      written = (we_a && wa_a == a) || (we_b && wa_b == a);
      if (byp != 0 && written && !(set_busy && sb_addr == a)) return 1'b0;
      return pend[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         mem[i]  = 32'h0;
         pend[i] = 1'b0;
      end
   endtask

   // Called right after a rising edge, while the inputs sampled there are still applied.
   task automatic model_edge();
      if (!rst_n) return;
      if (we_a && wa_a != 0) begin mem[wa_a] = wd_a; pend[wa_a] = 1'b0; end
      if (we_b && wb_nz()) begin mem[wa_b] = wd_b; pend[wa_b] = 1'b0; end
      if (set_busy && sb_addr != 0) pend[sb_addr] = 1'b1;
   endtask

   function automatic logic wb_nz();
      return wa_b != 0;
   endfunction

   task automatic idle();
      we_a = 0; we_b = 0; set_busy = 0;
      wa_a = 0; wa_b = 0; sb_addr = 0;
      wd_a = 0; wd_b = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0;
      model_clear();
      #2;
      for (int a = 0; a < 32; a++) begin
         for (int p = 0; p < 3; p++) ra[p] = 5'(a);
         #1;
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 3; p++) begin
               n_tests++;
               if (rdv[d][p] !== 32'h0 || bsv[d][p] !== 1'b0) begin
                  n_fail++;
                  $display("FAIL reset_state inst%0d port%0d addr%0d: rd=%h busy=%b, need 0/0",
                           d, p, a, rdv[d][p], bsv[d][p]);
               end
            end
      end
      @(negedge clk);
      rst_n = 1;
      tick();
   endtask

   task automatic test_bypass();
      idle();
      we_a = 1; wa_a = 5; wd_a = 32'hDEAD_BEEF; ra[0] = 5;
      #1;
      n_tests++;
      if (rdv[1][0] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL bypass_same_cycle: rd1=%h, need deadbeef", rdv[1][0]);
      end
      n_tests++;
      if (rdv[0][0] !== 32'h0) begin
         n_fail++; $display("FAIL nobypass_same_cycle: rd1=%h, need 0", rdv[0][0]);
      end
      tick();
      idle();
      #1;
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (rdv[d][0] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL bypass_next_cycle inst%0d: rd1=%h, need deadbeef", d, rdv[d][0]);
         end
      end
      tick();
   endtask

   task automatic test_dual_write();
      idle();
      we_a = 1; wa_a = 7; wd_a = 32'h11;
      we_b = 1; wa_b = 7; wd_b = 32'h22;
      ra[1] = 7;
      #1;
      n_tests++;
      if (rdv[1][1] !== 32'h22) begin
         n_fail++; $display("FAIL collide_bypass: rd2=%h, need 22", rdv[1][1]);
      end
      tick();
      idle();
      we_a = 1; wa_a = 0; wd_a = 32'hFFFF; ra[1] = 0; ra[2] = 7;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (rdv[d][1] !== 32'h0) begin
            n_fail++; $display("FAIL reg0_write_same inst%0d: rd2=%h, need 0", d, rdv[d][1]);
         end
         n_tests++;
         if (rdv[d][2] !== 32'h22) begin
            n_fail++; $display("FAIL collide_commit inst%0d: rd3=%h, need 22", d, rdv[d][2]);
         end
      end
      tick();
      idle();
      #1;
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (rdv[d][1] !== 32'h0 || bsv[d][1] !== 1'b0) begin
            n_fail++; $display("FAIL reg0_after inst%0d: rd2=%h busy=%b, need 0/0",
                               d, rdv[d][1], bsv[d][1]);
         end
      end
      tick();
   endtask

   task automatic test_scoreboard();
      idle();
      set_busy = 1; sb_addr = 9; ra[2] = 9;
      #1;
      n_tests++;
      if (bsv[1][2] !== 1'b0) begin
         n_fail++; $display("FAIL busy_before_edge: busy3=%b, need 0", bsv[1][2]);
      end
      tick();
      idle();
      #1;
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (bsv[d][2] !== 1'b1) begin
            n_fail++; $display("FAIL busy_set inst%0d: busy3=%b, need 1", d, bsv[d][2]);
         end
      end
      we_b = 1; wa_b = 9; wd_b = 32'h55;
      #1;
      n_tests++;
      if (bsv[1][2] !== 1'b0) begin
         n_fail++; $display("FAIL busy_bypass_clear: busy3=%b, need 0", bsv[1][2]);
      end
      n_tests++;
      if (bsv[0][2] !== 1'b1) begin
         n_fail++; $display("FAIL busy_nobypass_hold: busy3=%b, need 1", bsv[0][2]);
      end
      tick();
      idle();
      #1;
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (bsv[d][2] !== 1'b0 || rdv[d][2] !== 32'h55) begin
            n_fail++; $display("FAIL busy_cleared inst%0d: busy3=%b rd3=%h, need 0/55",
                               d, bsv[d][2], rdv[d][2]);
         end
      end
      set_busy = 1; sb_addr = 9; we_a = 1; wa_a = 9; wd_a = 32'h66;
      tick();
      idle();
      #1;
      for (int d = 0; d < 2; d++) begin
         n_tests++;
         if (bsv[d][2] !== 1'b1 || rdv[d][2] !== 32'h66) begin
            n_fail++; $display("FAIL producer_wins inst%0d: busy3=%b rd3=%h, need 1/66",
                               d, bsv[d][2], rdv[d][2]);
         end
      end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         idle();
         we_a     = 1'($urandom);
         we_b     = 1'($urandom);
         set_busy = 1'($urandom);
         wa_a     = 5'($urandom_range(0, 7));
         wa_b     = 5'($urandom_range(0, 7));
         sb_addr  = 5'($urandom_range(0, 7));
         wd_a     = $urandom;
         wd_b     = $urandom;
         for (int p = 0; p < 3; p++) ra[p] = 5'($urandom_range(0, 7));
         if (c % 16 == 0) ra[0] = 5'($urandom);
         #1;
         for (int d = 0; d < 2; d++)
            for (int p = 0; p < 3; p++) begin
               n_tests++;
               if (rdv[d][p] !== m_rd(ra[p], d) || bsv[d][p] !== m_busy(ra[p], d)) begin
                  n_fail++;
                  $display("FAIL random c%0d inst%0d port%0d addr%0d: rd=%h busy=%b, need %h/%b",
                           c, d, p, ra[p], rdv[d][p], bsv[d][p], m_rd(ra[p], d),
                           m_busy(ra[p], d));
               end
            end
         tick();
      end
   endtask

   task automatic test_async_reset();
      idle();
      we_a = 1; wa_a = 1; wd_a = 32'hA;
      we_b = 1; wa_b = 2; wd_b = 32'hA;
      tick();
      idle();
      we_a = 1; wa_a = 3; wd_a = 32'hA;
      set_busy = 1; sb_addr = 4;
      tick();
      idle();
      ra[0] = 1; ra[1] = 3; ra[2] = 4;
      #1;
      n_tests++;
      if (rdv[1][0] !== 32'hA || rdv[1][1] !== 32'hA || bsv[1][2] !== 1'b1) begin
         n_fail++; $display("FAIL preload: rd1=%h rd2=%h busy3=%b, need a/a/1",
                            rdv[1][0], rdv[1][1], bsv[1][2]);
      end
      // Mid-cycle assertion, with a write and a set_busy that must be ignored.
      rst_n = 0;
      model_clear();
      we_a = 1; wa_a = 1; wd_a = 32'h123;
      set_busy = 1; sb_addr = 5;
      #1;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 3; p++) begin
            n_tests++;
            if (rdv[d][p] !== 32'h0 || bsv[d][p] !== 1'b0) begin
               n_fail++; $display("FAIL async_reset inst%0d port%0d: rd=%h busy=%b, need 0/0",
                                  d, p, rdv[d][p], bsv[d][p]);
            end
         end
      tick();
      @(negedge clk);
      idle();
      rst_n = 1;
      ra[0] = 1; ra[1] = 2; ra[2] = 5;
      #1;
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 3; p++) begin
            n_tests++;
            if (rdv[d][p] !== 32'h0 || bsv[d][p] !== 1'b0) begin
               n_fail++; $display("FAIL reset_ignores_wr inst%0d port%0d: rd=%h busy=%b, need 0/0",
                                  d, p, rdv[d][p], bsv[d][p]);
            end
         end
      tick();
   endtask

   initial begin
      idle();
      for (int p = 0; p < 3; p++) ra[p] = 0;
      model_clear();
      test_reset();
      test_bypass();
      test_dual_write();
      test_scoreboard();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = reads return stored value only.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ra1, ra2, ra3  input  ADDR_W  read addresses, ports 1-3.
REQ-007 rd1, rd2, rd3  output  DATA_W  read data, ports 1-3, combinational.
REQ-008 busy1, busy2, busy3  output  1  pending-write flag of ra1/ra2/ra3, combinational.
REQ-009 we_a  input  1  write enable, port A (ALU writeback).
REQ-010 wa_a  input  ADDR_W  write address, port A.
REQ-011 wd_a  input  DATA_W  write data, port A.
REQ-012 we_b, wa_b, wd_b  input  1/ADDR_W/DATA_W  write enable/address/data, port B (load writeback).
REQ-013 set_busy  input  1  mark register sb_addr as having an outstanding producer.
REQ-014 sb_addr  input  ADDR_W  register to mark busy.

Function
REQ-015 Writes commit on rising clk when the port's enable is 1 and its address is nonzero.
REQ-016 Register 0 reads as 0 on every port and is never written and never busy.
REQ-017 Both ports writing the same nonzero address in one cycle: port B data commits, port A discarded.
REQ-018 BYPASS=1: read address equals an enabled nonzero write address in the same cycle -> rd returns that write data (port B over port A); otherwise the stored value.
REQ-019 BYPASS=0: rd reflects only values committed on prior edges.
REQ-020 Scoreboard: one busy bit per register, all cleared at reset.
REQ-021 set_busy=1 with nonzero sb_addr sets busy[sb_addr] on the next edge.
REQ-022 A committed write (either port) clears busy[wa] on the same edge.
REQ-023 set_busy and a write to the same register in one cycle: busy ends set (new producer wins).
REQ-024 busyN = busy[raN], except BYPASS=1 and raN matches an enabled write this cycle -> busyN=0, unless set_busy targets the same address in that cycle.
REQ-025 set_busy with sb_addr=0 has no effect.
REQ-026 No read latency: rd/busy depend only on current inputs and state.

Reset
REQ-027 rst_n low clears every register to 0 and every busy bit to 0 immediately, independent of clk.
REQ-028 During reset writes and set_busy are ignored; rd*=0, busy*=0.
REQ-029 Deassertion mid-cycle: first state update on the next rising clk.

Structure
REQ-030 Shared package holds DATA_W/ADDR_W defaults and the REG_ZERO address constant.
REQ-031 Busy-bit array, set/clear priority and busy lookup form one sub-module, rf_scoreboard.
REQ-032 Data storage, write arbitration and bypass mux stay in regfile_sb.

Verification
REQ-033 Reset, then read all 32 addresses on all ports -> rd=0, busy=0.
REQ-034 we_a=1, wa_a=5, wd_a=0xDEADBEEF, ra1=5 same cycle -> rd1=0xDEADBEEF with BYPASS=1, 0 with BYPASS=0; next cycle both give 0xDEADBEEF.
REQ-035 we_a/we_b both to reg 7, wd_a=0x11, wd_b=0x22 -> reg 7 = 0x22; write to reg 0 with 0xFFFF -> reads 0.
REQ-036 set_busy reg 9 -> busy=1 next cycle; we_b reg 9 0x55 -> same-cycle busy=0 (BYPASS=1), cleared after edge; set_busy+write reg 9 same cycle -> busy stays 1.
REQ-037 Load regs 1-3 with 0xA, set busy reg 4, assert rst_n=0 between edges -> all rd=0 and busy=0 at once, no wait for clk.
